// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode constants, instruction field
// positions and the small opcode-class helpers used by the decode stage.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SA_LSB     = 6;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [5:0]  funct;
    logic [15:0] imm;
  } instr_fields_t;

  function automatic instr_fields_t split_instr(input logic [31:0] instr);
    instr_fields_t f;
    f.opcode = instr[OPCODE_LSB +: 6];
    f.rs     = instr[RS_LSB +: 5];
    f.rt     = instr[RT_LSB +: 5];
    f.rd     = instr[RD_LSB +: 5];
    f.sa     = instr[SA_LSB +: 5];
    f.funct  = instr[5:0];
    f.imm    = instr[15:0];
    return f;
  endfunction

  // R-type, stores and BEQ/BNE read rt as a source; everything else writes it.
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op[5:3] == 3'b101) || (op[5:1] == 5'b00010);
  endfunction

  function automatic logic zero_ext(input logic [5:0] op);
    return (op[5:2] == 4'b0011);
  endfunction

endpackage

// File: rtl/instruction_decode_pipe_if.sv
// Signal bundle between IF/ID, WB, the decode stage and EX.
// The slave modport is the decode stage; the master drives it.
interface instruction_decode_pipe_if #(
    parameter int NBITS = 32,
    parameter int NREGS = 32
);
    localparam int RSEL = $clog2(NREGS);

    logic             i_valid;
    logic [NBITS-1:0] i_pc;
    logic [31:0]      i_instr;
    logic             i_flush;
    logic             i_ex_mem_rd;
    logic [RSEL-1:0]  i_ex_rt;
    logic             i_wr_en;
    logic [RSEL-1:0]  i_wr_sel;
    logic [NBITS-1:0] i_wr_data;

    logic             o_stall;
    logic             o_valid;
    logic [5:0]       o_opcode;
    logic [5:0]       o_funct;
    logic [4:0]       o_sa;
    logic [RSEL-1:0]  o_rs;
    logic [RSEL-1:0]  o_rt;
    logic [RSEL-1:0]  o_rd;
    logic [NBITS-1:0] o_rs_data;
    logic [NBITS-1:0] o_rt_data;
    logic [NBITS-1:0] o_imm_ext;
    logic [NBITS-1:0] o_pc;

    modport master (
        output i_valid, i_pc, i_instr, i_flush, i_ex_mem_rd, i_ex_rt,
               i_wr_en, i_wr_sel, i_wr_data,
        input  o_stall, o_valid, o_opcode, o_funct, o_sa, o_rs, o_rt, o_rd,
               o_rs_data, o_rt_data, o_imm_ext, o_pc
    );

    modport slave (
        input  i_valid, i_pc, i_instr, i_flush, i_ex_mem_rd, i_ex_rt,
               i_wr_en, i_wr_sel, i_wr_data,
        output o_stall, o_valid, o_opcode, o_funct, o_sa, o_rs, o_rt, o_rd,
               o_rs_data, o_rt_data, o_imm_ext, o_pc
    );
endinterface

// File: rtl/id_register_file.sv
// Register file for the decode stage: two combinational read ports with
// write-through bypass from WB, one write port, synchronous reset.
module id_register_file #(
    parameter int NBITS    = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    localparam int RSEL    = $clog2(NREGS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [RSEL-1:0]  i_wr_sel,
    input  logic [NBITS-1:0] i_wr_data,
    input  logic [RSEL-1:0]  i_rd_sel_a,
    input  logic [RSEL-1:0]  i_rd_sel_b,
    output logic [NBITS-1:0] o_rd_data_a,
    output logic [NBITS-1:0] o_rd_data_b
);
    logic [NBITS-1:0] r_regs [NREGS];
    logic             w_wr_ok;
    logic [RSEL-1:0]  w_sel  [2];
    logic [NBITS-1:0] w_data [2];

    assign w_wr_ok  = i_wr_en && !((ZERO_REG != 0) && (i_wr_sel == '0));
    assign w_sel[0] = i_rd_sel_a;
    assign w_sel[1] = i_rd_sel_b;

    // NOTE: the reset clears every entry, so the array maps to flops, not RAM;
    // that is required because reset must leave all registers reading zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (w_wr_ok) begin
            // NOTE: non-blocking so every read in this cycle sees pre-edge state.
            r_regs[i_wr_sel] <= i_wr_data;
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            // NOTE: default first so no path leaves w_data unassigned (no latch).
            w_data[p] = r_regs[w_sel[p]];
            if (w_wr_ok && (i_wr_sel == w_sel[p])) w_data[p] = i_wr_data;
            else if ((ZERO_REG != 0) && (w_sel[p] == '0)) w_data[p] = '0;
        end
    end

    assign o_rd_data_a = w_data[0];
    assign o_rd_data_b = w_data[1];
endmodule

// File: rtl/instruction_decode_pipe.sv
// MIPS decode stage: field split, immediate extension, register read with
// WB bypass, load-use stall detection and the ID/EX output register.
module instruction_decode_pipe
    import mips_pkg::*;
#(
    parameter int NBITS    = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    localparam int RSEL    = $clog2(NREGS)
) (
    input logic                      i_clk,
    input logic                      i_rst,
    instruction_decode_pipe_if.slave bus
);
    if (NBITS < 32) begin : g_nbits_check
        $error("instruction_decode_pipe: NBITS must be at least 32");
    end

    typedef struct packed {
        logic             valid;
        logic [5:0]       opcode;
        logic [5:0]       funct;
        logic [4:0]       sa;
        logic [RSEL-1:0]  rs;
        logic [RSEL-1:0]  rt;
        logic [RSEL-1:0]  rd;
        logic [NBITS-1:0] rs_data;
        logic [NBITS-1:0] rt_data;
        logic [NBITS-1:0] imm_ext;
        logic [NBITS-1:0] pc;
    } idex_t;

    instr_fields_t    w_f;
    logic [RSEL-1:0]  w_rs, w_rt, w_rd;
    logic [NBITS-1:0] w_rs_data, w_rt_data, w_imm_ext;
    logic             w_stall, w_bubble;
    idex_t            w_next, r_idex;

    assign w_f  = split_instr(bus.i_instr);
    assign w_rs = RSEL'(w_f.rs);
    assign w_rt = RSEL'(w_f.rt);
    assign w_rd = RSEL'(w_f.rd);

    id_register_file #(.NBITS(NBITS), .NREGS(NREGS), .ZERO_REG(ZERO_REG)) u_rf (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_wr_en     (bus.i_wr_en),
        .i_wr_sel    (bus.i_wr_sel),
        .i_wr_data   (bus.i_wr_data),
        .i_rd_sel_a  (w_rs),
        .i_rd_sel_b  (w_rt),
        .o_rd_data_a (w_rs_data),
        .o_rd_data_b (w_rt_data)
    );

    always_comb begin
        if (w_f.opcode == OP_LUI)    w_imm_ext = NBITS'({w_f.imm, 16'h0000});
        else if (zero_ext(w_f.opcode)) w_imm_ext = NBITS'(w_f.imm);
        else                         w_imm_ext = {{(NBITS-16){w_f.imm[15]}}, w_f.imm};
    end

    // A load in EX whose target is read here must reach WB before we issue.
    assign w_stall = bus.i_valid && !bus.i_flush && bus.i_ex_mem_rd &&
                     (bus.i_ex_rt != '0) &&
                     ((bus.i_ex_rt == w_rs) || (uses_rt(w_f.opcode) && (bus.i_ex_rt == w_rt)));
    assign w_bubble = bus.i_flush || w_stall || !bus.i_valid;

    always_comb begin
        w_next         = '0;
        w_next.valid   = 1'b1;
        w_next.opcode  = w_f.opcode;
        w_next.funct   = w_f.funct;
        w_next.sa      = w_f.sa;
        w_next.rs      = w_rs;
        w_next.rt      = w_rt;
        w_next.rd      = w_rd;
        w_next.rs_data = w_rs_data;
        w_next.rt_data = w_rt_data;
        w_next.imm_ext = w_imm_ext;
        w_next.pc      = bus.i_pc;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || w_bubble) r_idex <= '0;
        else                   r_idex <= w_next;
    end

    assign bus.o_stall   = w_stall;
    assign bus.o_valid   = r_idex.valid;
    assign bus.o_opcode  = r_idex.opcode;
    assign bus.o_funct   = r_idex.funct;
    assign bus.o_sa      = r_idex.sa;
    assign bus.o_rs      = r_idex.rs;
    assign bus.o_rt      = r_idex.rt;
    assign bus.o_rd      = r_idex.rd;
    assign bus.o_rs_data = r_idex.rs_data;
    assign bus.o_rt_data = r_idex.rt_data;
    assign bus.o_imm_ext = r_idex.imm_ext;
    assign bus.o_pc      = r_idex.pc;
endmodule

// File: tb/tb_instruction_decode_pipe.sv
// Self-checking bench for instruction_decode_pipe: directed cases with literal
// expectations, then randomized traffic against a behavioural model.
module tb_instruction_decode_pipe;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instruction_decode_pipe_if #(.NBITS(32), .NREGS(32)) bus ();

    instruction_decode_pipe #(.NBITS(32), .NREGS(32), .ZERO_REG(1)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] model_rf [32];
    logic [31:0] e_valid, e_op, e_funct, e_sa, e_rs, e_rt, e_rd;
    logic [31:0] e_rsd, e_rtd, e_imm, e_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                          input int sa, input int funct);
        return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (32'(sa) << 6) | 32'(funct);
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        return (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
    endfunction

    // Model helpers, phrased as arithmetic on opcode numbers.
    function automatic bit model_uses_rt(input int op);
        return (op == 0) || (op >= 40 && op <= 47) || (op == 4) || (op == 5);
    endfunction

    function automatic logic [31:0] model_ext(input int op, input logic [31:0] imm);
        if (op == 15)                return imm * 65536;
        if (op >= 12 && op <= 14)    return imm;
        if (imm >= 32768)            return imm + 32'hFFFF_0000;
        return imm;
    endfunction

    function automatic logic [31:0] model_read(input int sel, input bit wr_en, input int wr_sel,
                                               input logic [31:0] wr_data);
        if (sel == 0)                  return 32'h0;
        if (wr_en && wr_sel == sel)    return wr_data;
        return model_rf[sel];
    endfunction

    task automatic clear_expect();
        e_valid = 0; e_op = 0; e_funct = 0; e_sa = 0; e_rs = 0; e_rt = 0; e_rd = 0;
        e_rsd = 0; e_rtd = 0; e_imm = 0; e_pc = 0;
    endtask

    task automatic step(input logic [31:0] instr, input bit valid, input bit flush,
                        input bit ex_ld, input int ex_rt, input bit wr_en, input int wr_sel,
                        input logic [31:0] wr_data, input bit do_rst, input logic [31:0] pc);
        int  op, rs, rt;
        bit  exp_stall;
        rst             = do_rst;
        bus.i_instr     = instr;
        bus.i_valid     = valid;
        bus.i_flush     = flush;
        bus.i_ex_mem_rd = ex_ld;
        bus.i_ex_rt     = 5'(ex_rt);
        bus.i_wr_en     = wr_en;
        bus.i_wr_sel    = 5'(wr_sel);
        bus.i_wr_data   = wr_data;
        bus.i_pc        = pc;
        #1;
        op = int'(instr >> 26);
        rs = int'((instr >> 21) & 32'd31);
        rt = int'((instr >> 16) & 32'd31);
        exp_stall = valid && !flush && ex_ld && (ex_rt != 0) &&
                    ((ex_rt == rs) || (model_uses_rt(op) && ex_rt == rt));
        check("o_stall", 32'(bus.o_stall), 32'(exp_stall));
        if (do_rst) begin
            clear_expect();
            for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
        end else begin
            if (flush || exp_stall || !valid) clear_expect();
            else begin
                e_valid = 1;
                e_op    = 32'(op);
                e_rs    = 32'(rs);
                e_rt    = 32'(rt);
                e_rd    = (instr >> 11) & 32'd31;
                e_sa    = (instr >> 6) & 32'd31;
                e_funct = instr & 32'd63;
                e_rsd   = model_read(rs, wr_en, wr_sel, wr_data);
                e_rtd   = model_read(rt, wr_en, wr_sel, wr_data);
                e_imm   = model_ext(op, instr & 32'hFFFF);
                e_pc    = pc;
            end
            if (wr_en && wr_sel != 0) model_rf[wr_sel] = wr_data;
        end
        @(posedge clk);
        #1;
        check("o_valid",   32'(bus.o_valid),  e_valid);
        check("o_opcode",  32'(bus.o_opcode), e_op);
        check("o_funct",   32'(bus.o_funct),  e_funct);
        check("o_sa",      32'(bus.o_sa),     e_sa);
        check("o_rs",      32'(bus.o_rs),     e_rs);
        check("o_rt",      32'(bus.o_rt),     e_rt);
        check("o_rd",      32'(bus.o_rd),     e_rd);
        check("o_rs_data", bus.o_rs_data,     e_rsd);
        check("o_rt_data", bus.o_rt_data,     e_rtd);
        check("o_imm_ext", bus.o_imm_ext,     e_imm);
        check("o_pc",      bus.o_pc,          e_pc);
        @(negedge clk);
    endtask

    task automatic idle(input bit do_rst);
        step(32'h0, 0, 0, 0, 0, 0, 0, 32'h0, do_rst, 32'h0);
    endtask

    logic [5:0] op_pool [11];

    initial begin
        op_pool = '{OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
                    OP_LW, OP_SW, OP_BEQ, OP_BNE, 6'b000000};

        // Reset, then idle, then every register reads zero.
        idle(1);
        idle(1);
        check("reset_valid", 32'(bus.o_valid), 32'h0);
        check("reset_pc",    bus.o_pc,         32'h0);
        idle(0);
        for (int i = 1; i < 32; i++) begin
            step(rtype(i, i, 1, 0, 32), 1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h100);
            check("reset_rf_read", bus.o_rs_data | bus.o_rt_data, 32'h0);
        end

        // WB write of r5 bypassed into ADD r3,r5,r5 in the same cycle.
        step(rtype(5, 5, 3, 0, 32), 1, 0, 0, 0, 1, 5, 32'hDEAD_BEEF, 0, 32'h0000_0404);
        check("bypass_rs", bus.o_rs_data, 32'hDEAD_BEEF);
        check("bypass_rt", bus.o_rt_data, 32'hDEAD_BEEF);
        check("bypass_rd", 32'(bus.o_rd), 32'd3);
        check("bypass_v",  32'(bus.o_valid), 32'd1);

        // Immediate extension.
        step(itype(OP_ADDI, 0, 2, 16'hFFFF), 1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h8);
        check("addi_ext", bus.o_imm_ext, 32'hFFFF_FFFF);
        step(itype(OP_ORI, 0, 2, 16'hFFFF), 1, 0, 0, 0, 0, 0, 32'h0, 0, 32'hC);
        check("ori_ext", bus.o_imm_ext, 32'h0000_FFFF);
        step(itype(OP_LUI, 0, 2, 16'h1234), 1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h10);
        check("lui_ext", bus.o_imm_ext, 32'h1234_0000);

        // Load-use hazard on SW's rt, then release.
        step(itype(OP_SW, 7, 4, 16'h0), 1, 0, 1, 4, 0, 0, 32'h0, 0, 32'h14);
        check("sw_stall_bubble", 32'(bus.o_valid), 32'h0);
        step(itype(OP_SW, 7, 4, 16'h0), 1, 0, 0, 4, 0, 0, 32'h0, 0, 32'h14);
        check("sw_issue", 32'(bus.o_valid), 32'h1);

        // No hazard: load target r0, or ADDI whose rt is a destination.
        step(itype(OP_SW, 7, 0, 16'h0), 1, 0, 1, 0, 0, 0, 32'h0, 0, 32'h18);
        check("ex_rt0_no_stall", 32'(bus.o_valid), 32'h1);
        step(itype(OP_ADDI, 1, 4, 16'h5), 1, 0, 1, 4, 0, 0, 32'h0, 0, 32'h1C);
        check("addi_no_stall", 32'(bus.o_valid), 32'h1);

        // Flush overrides stall.
        step(itype(OP_SW, 7, 4, 16'h0), 1, 1, 1, 4, 0, 0, 32'h0, 0, 32'h20);
        check("flush_bubble", 32'(bus.o_valid), 32'h0);

        // Writes to r0 are ignored, both bypassed and stored.
        step(rtype(0, 0, 1, 0, 32), 1, 0, 0, 0, 1, 0, 32'h55, 0, 32'h24);
        check("r0_bypass", bus.o_rs_data, 32'h0);
        step(rtype(0, 0, 1, 0, 32), 1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h28);
        check("r0_stored", bus.o_rs_data, 32'h0);

        // Reset mid-stream clears outputs and the register file.
        step(rtype(5, 5, 3, 0, 32), 1, 0, 0, 0, 0, 0, 32'h0, 1, 32'h2C);
        check("midrst_valid", 32'(bus.o_valid), 32'h0);
        step(rtype(5, 5, 3, 0, 32), 1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h30);
        check("midrst_rf", bus.o_rs_data, 32'h0);

        // Randomized traffic over a narrow register window to provoke hazards.
        for (int n = 0; n < 600; n++) begin
            logic [5:0]  op;
            logic [31:0] instr;
            op = op_pool[$urandom_range(0, 10)];
            if (op == OP_RTYPE)
                instr = rtype($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 31),
                              $urandom_range(0, 31), $urandom_range(0, 63));
            else
                instr = itype(op, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
            if ($urandom_range(0, 15) == 0) instr = $urandom;
            step(instr, $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom,
                 $urandom_range(0, 99) == 0, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
